// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Owns the program counter and fetch sequencing of the processor. A rising edge
// on start launches one of three resident programs. While running, the PC
// advances by +1 each cycle or by a signed branch offset. The run ends on a halt
// instruction, or on a fetch address that would fall outside 0..MAX_ADDR. The
// block reports done/fault and a saturating count of run cycles.
//
// Ports
//   Clk        in   1   clock, all state updates on the rising edge
//   Reset      in   1   asynchronous, active-high; clears all state at once
//   start      in   1   launch request (level); only a 0->1 edge launches
//   prog_sel   in   2   program select, sampled on the launch edge only
//   stall      in   1   hold PC this cycle (RUN only)
//   halt_req   in   1   current instruction is halt (RUN only)
//   branch_en  in   1   apply target as PC offset this cycle (RUN only)
//   target     in   D   signed two's-complement branch offset
//   prog_ctr   out  D   current fetch address
//   running    out  1   1 while in RUN
//   done       out  1   1 while in DONE (normal halt or fault)
//   fault      out  1   1 in DONE when the run ended on an out-of-range fetch
//   cycle_cnt  out  CW  RUN cycles of the current/last launch, saturating
//   state_dbg  out  2   raw FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Control protocol: start is a plain level with no acknowledge. A launch is the
// cycle where start is high and was low on the previous clock. A launch is
// honoured only from IDLE or DONE; while RUN it is ignored. The caller must drop
// start and raise it again to request another launch.
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int D        = 12,
    parameter int CW       = 16,
    parameter int P1_START = 0,
    parameter int P2_START = 200,
    parameter int P3_START = 500,
    parameter int MAX_ADDR = 1023
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          start,
    input  logic [1:0]    prog_sel,
    input  logic          stall,
    input  logic          halt_req,
    input  logic          branch_en,
    input  logic [D-1:0]  target,
    output logic [D-1:0]  prog_ctr,
    output logic          running,
    output logic          done,
    output logic          fault,
    output logic [CW-1:0] cycle_cnt,
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [D-1:0] ADDR_P1  = D'(P1_START);
    localparam logic [D-1:0] ADDR_P2  = D'(P2_START);
    localparam logic [D-1:0] ADDR_P3  = D'(P3_START);
    localparam logic [D-1:0] ADDR_MAX = D'(MAX_ADDR);

    state_t        state;
    state_t        state_d;
    logic [D-1:0]  pc_d;
    logic          fault_d;
    logic [CW-1:0] cnt_d;
    logic          start_q;
    logic          launch;
    logic [D-1:0]  start_addr;
    logic [D:0]    step;
    logic [D:0]    next_pc;
    logic          out_of_range;

    assign launch = start & ~start_q;

    always_comb begin
        start_addr = ADDR_P1;
        case (prog_sel)
            2'd0:    start_addr = ADDR_P1;
            2'd1:    start_addr = ADDR_P2;
            default: start_addr = ADDR_P3;
        endcase
    end

    // Next address is formed one bit wider than the PC, so nothing wraps.
    // The PC is zero-extended and the offset is sign-extended. Bit D of the
    // sum is set exactly when the result lies outside 0..2^D-1. That covers a
    // negative address and an overshoot beyond the PC range.
    assign step         = branch_en ? {target[D-1], target} : (D+1)'(1);
    assign next_pc      = {1'b0, prog_ctr} + step;
    assign out_of_range = next_pc[D] | (next_pc[D-1:0] > ADDR_MAX);

    always_comb begin
        state_d = state;
        pc_d    = prog_ctr;
        fault_d = fault;
        cnt_d   = cycle_cnt;
        case (state)
            S_IDLE, S_DONE: begin
                if (launch) begin
                    state_d = S_RUN;
                    pc_d    = start_addr;
                    cnt_d   = '0;
                    fault_d = 1'b0;
                end
            end
            S_RUN: begin
                // Every RUN cycle counts, including stall and halt cycles.
                if (!(&cycle_cnt)) begin
                    cnt_d = cycle_cnt + CW'(1);
                end
                // Priority: stall > halt_req > branch/increment.
                if (!stall) begin
                    if (halt_req) begin
                        state_d = S_DONE;
                    end else if (out_of_range) begin
                        state_d = S_DONE;
                        fault_d = 1'b1;
                    end else begin
                        pc_d = next_pc[D-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // start_q resets high, so a start held through reset release does not
    // launch.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= S_IDLE;
            prog_ctr  <= '0;
            fault     <= 1'b0;
            cycle_cnt <= '0;
            start_q   <= 1'b1;
        end else begin
            state     <= state_d;
            prog_ctr  <= pc_d;
            fault     <= fault_d;
            cycle_cnt <= cnt_d;
            start_q   <= start;
        end
    end

    assign running   = (state == S_RUN);
    assign done      = (state == S_DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Bench for pc_sequencer. Each clock, the tick task runs a small behavioural
// model of the sequencer on the inputs being driven. It pushes the expected
// output vector to exp_q. A negedge monitor pops that entry and compares it
// with the DUT. The scenario tasks also add directed checks against literal
// values. The counter width is narrowed to 5 bits so saturation can be reached.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

  localparam int D    = 12;
  localparam int CW   = 5;
  localparam int W    = 2 + 3 + D + CW;
  localparam int CMAX = (1 << CW) - 1;

  logic          Clk;
  logic          Reset;
  logic          start;
  logic [1:0]    prog_sel;
  logic          stall;
  logic          halt_req;
  logic          branch_en;
  logic [D-1:0]  target;
  logic [D-1:0]  prog_ctr;
  logic          running;
  logic          done;
  logic          fault;
  logic [CW-1:0] cycle_cnt;
  logic [1:0]    state_dbg;

  pc_sequencer #(.D(D), .CW(CW)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .start     (start),
    .prog_sel  (prog_sel),
    .stall     (stall),
    .halt_req  (halt_req),
    .branch_en (branch_en),
    .target    (target),
    .prog_ctr  (prog_ctr),
    .running   (running),
    .done      (done),
    .fault     (fault),
    .cycle_cnt (cycle_cnt),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- scoreboard ----------------
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  logic [W-1:0] mon_act;

  // model state: 0 IDLE, 1 RUN, 2 DONE
  int   m_state = 0;
  int   m_pc    = 0;
  int   m_cnt   = 0;
  logic m_fault = 1'b0;
  logic m_start_q = 1'b1;

  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = {state_dbg, running, done, fault, prog_ctr, cycle_cnt};
      n_checks++;
      if (mon_act !== mon_exp) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t: got %h expected %h", $time, mon_act, mon_exp);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    logic launch;
    int nxt;
    logic signed [D-1:0] ts;
    logic [1:0] st;
    if (Reset) begin
      m_state = 0; m_pc = 0; m_cnt = 0; m_fault = 1'b0; m_start_q = 1'b1;
    end else begin
      launch = start && !m_start_q;
      m_start_q = start;
      if (m_state == 1) begin
        if (m_cnt < CMAX) m_cnt++;
        if (!stall) begin
          if (halt_req) begin
            m_state = 2;
          end else begin
            ts  = target;
            nxt = m_pc + (branch_en ? int'(ts) : 1);
            if (nxt < 0 || nxt > 1023) begin
              m_state = 2; m_fault = 1'b1;
            end else begin
              m_pc = nxt;
            end
          end
        end
      end else if (launch) begin
        m_state = 1;
        m_pc    = (prog_sel == 2'd0) ? 0 : (prog_sel == 2'd1) ? 200 : 500;
        m_cnt   = 0;
        m_fault = 1'b0;
      end
    end
    st = 2'(m_state);
    exp_q.push_back({st, (m_state == 1), (m_state == 2), m_fault, D'(m_pc), CW'(m_cnt)});
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic do_launch(input logic [1:0] sel);
    start = 1'b0;
    tick();
    start = 1'b1;
    prog_sel = sel;
    tick();
  endtask

  task automatic clear_ctrl();
    stall = 1'b0; halt_req = 1'b0; branch_en = 1'b0; target = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    Reset = 1'b1; start = 1'b0; prog_sel = 2'd0; clear_ctrl();
    tick(); tick();
    n_checks++; if (prog_ctr !== 12'd0) begin n_fail++; $display("FAIL reset_pc: got %0d expected 0", prog_ctr); end
    n_checks++; if ({running, done, fault} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {running, done, fault}); end
    n_checks++; if (cycle_cnt !== 5'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", cycle_cnt); end
    n_checks++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
    Reset = 1'b0;
    tick();
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL idle_no_start: got %b expected 0", running); end
  endtask

  task automatic test_increment();
    do_launch(2'd0);
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL launch_running: got %b expected 1", running); end
    n_checks++; if (prog_ctr !== 12'd0) begin n_fail++; $display("FAIL launch_pc0: got %0d expected 0", prog_ctr); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_checks++; if (prog_ctr !== 12'(i)) begin n_fail++; $display("FAIL incr_pc: got %0d expected %0d", prog_ctr, i); end
    end
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    tick();  // start still high in DONE: must not relaunch
    n_checks++; if ({running, done} !== 2'b01) begin n_fail++; $display("FAIL done_no_relaunch: got %b expected 01", {running, done}); end
  endtask

  task automatic test_branch();
    do_launch(2'd1);
    n_checks++; if (prog_ctr !== 12'd200) begin n_fail++; $display("FAIL p2_start: got %0d expected 200", prog_ctr); end
    branch_en = 1'b1; target = 12'hFA6;  // -90
    tick();
    n_checks++; if (prog_ctr !== 12'd110) begin n_fail++; $display("FAIL branch_back90: got %0d expected 110", prog_ctr); end
    target = 12'hF9B;  // -101
    tick();
    n_checks++; if (prog_ctr !== 12'd9) begin n_fail++; $display("FAIL branch_back101: got %0d expected 9", prog_ctr); end
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL branch_running: got %b expected 1", running); end
    clear_ctrl();
    halt_req = 1'b1; tick(); clear_ctrl();
  endtask

  task automatic test_halt();
    do_launch(2'd0);
    repeat (20) tick();
    n_checks++; if (prog_ctr !== 12'd20) begin n_fail++; $display("FAIL halt_pre_pc: got %0d expected 20", prog_ctr); end
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    n_checks++; if ({running, done, fault} !== 3'b010) begin n_fail++; $display("FAIL halt_flags: got %b expected 010", {running, done, fault}); end
    n_checks++; if (prog_ctr !== 12'd20) begin n_fail++; $display("FAIL halt_pc: got %0d expected 20", prog_ctr); end
    n_checks++; if (cycle_cnt !== 5'd21) begin n_fail++; $display("FAIL halt_cnt: got %0d expected 21", cycle_cnt); end
    tick();
    n_checks++; if ({done, prog_ctr, cycle_cnt} !== {1'b1, 12'd20, 5'd21}) begin n_fail++; $display("FAIL done_hold: got %b/%0d/%0d expected 1/20/21", done, prog_ctr, cycle_cnt); end
  endtask

  task automatic test_fault();
    do_launch(2'd0);
    tick(); tick();
    branch_en = 1'b1; target = 12'hFFB;  // -5
    tick(); clear_ctrl();
    n_checks++; if ({running, done, fault} !== 3'b011) begin n_fail++; $display("FAIL neg_fault_flags: got %b expected 011", {running, done, fault}); end
    n_checks++; if (prog_ctr !== 12'd2) begin n_fail++; $display("FAIL neg_fault_pc: got %0d expected 2", prog_ctr); end
    n_checks++; if (cycle_cnt !== 5'd3) begin n_fail++; $display("FAIL neg_fault_cnt: got %0d expected 3", cycle_cnt); end
    do_launch(2'd2);
    n_checks++; if ({prog_ctr, fault, done} !== {12'd500, 2'b00}) begin n_fail++; $display("FAIL p3_relaunch: got %0d/%b/%b expected 500/0/0", prog_ctr, fault, done); end
    branch_en = 1'b1; target = 12'd523;
    tick(); clear_ctrl();
    n_checks++; if ({prog_ctr, running} !== {12'd1023, 1'b1}) begin n_fail++; $display("FAIL branch_to_max: got %0d/%b expected 1023/1", prog_ctr, running); end
    tick();
    n_checks++; if ({done, fault, prog_ctr} !== {2'b11, 12'd1023}) begin n_fail++; $display("FAIL top_fault: got %b/%b/%0d expected 1/1/1023", done, fault, prog_ctr); end
  endtask

  task automatic test_stall();
    do_launch(2'd3);
    n_checks++; if (prog_ctr !== 12'd500) begin n_fail++; $display("FAIL sel3_start: got %0d expected 500", prog_ctr); end
    stall = 1'b1; halt_req = 1'b1; branch_en = 1'b1; target = 12'd5;
    tick();
    n_checks++; if ({running, prog_ctr, cycle_cnt} !== {1'b1, 12'd500, 5'd1}) begin n_fail++; $display("FAIL stall_hold: got %b/%0d/%0d expected 1/500/1", running, prog_ctr, cycle_cnt); end
    stall = 1'b0; branch_en = 1'b0;
    tick(); clear_ctrl();
    n_checks++; if ({done, fault, prog_ctr, cycle_cnt} !== {2'b10, 12'd500, 5'd2}) begin n_fail++; $display("FAIL stall_then_halt: got %b/%b/%0d/%0d expected 1/0/500/2", done, fault, prog_ctr, cycle_cnt); end
  endtask

  task automatic test_saturate();
    do_launch(2'd1);
    stall = 1'b1;
    repeat (40) tick();
    n_checks++; if ({cycle_cnt, running, prog_ctr} !== {5'd31, 1'b1, 12'd200}) begin n_fail++; $display("FAIL cnt_saturate: got %0d/%b/%0d expected 31/1/200", cycle_cnt, running, prog_ctr); end
    stall = 1'b0; halt_req = 1'b1;
    tick(); clear_ctrl();
    n_checks++; if ({done, cycle_cnt} !== {1'b1, 5'd31}) begin n_fail++; $display("FAIL cnt_sat_halt: got %b/%0d expected 1/31", done, cycle_cnt); end
  endtask

  task automatic test_reset_mid_run();
    do_launch(2'd0);
    tick(); tick(); tick();
    #2 Reset = 1'b1;
    #1;
    n_checks++; if ({state_dbg, running, prog_ctr, cycle_cnt} !== '0) begin n_fail++; $display("FAIL async_reset: got %0d/%b/%0d/%0d expected 0/0/0/0", state_dbg, running, prog_ctr, cycle_cnt); end
    tick();
    Reset = 1'b0;
    tick(); tick();
    n_checks++; if ({running, prog_ctr} !== {1'b0, 12'd0}) begin n_fail++; $display("FAIL held_start_no_launch: got %b/%0d expected 0/0", running, prog_ctr); end
    do_launch(2'd0);
    branch_en = 1'b1; target = 12'hFFB;
    tick(); clear_ctrl();
    n_checks++; if (fault !== 1'b1) begin n_fail++; $display("FAIL pc0_neg_fault: got %b expected 1", fault); end
    do_launch(2'd1);
    n_checks++; if ({prog_ctr, fault, done, running} !== {12'd200, 3'b001}) begin n_fail++; $display("FAIL relaunch_clears: got %0d/%b/%b/%b expected 200/0/0/1", prog_ctr, fault, done, running); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) start = ~start;
      prog_sel  = 2'($urandom_range(0, 3));
      stall     = ($urandom_range(0, 4) == 0);
      halt_req  = ($urandom_range(0, 19) == 0);
      branch_en = ($urandom_range(0, 3) == 0);
      target    = 12'($urandom_range(0, 80)) - 12'd40;
      tick();
    end
    clear_ctrl();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_increment();
    test_branch();
    test_halt();
    test_fault();
    test_stall();
    test_saturate();
    test_reset_mid_run();
    test_back_to_back();
    #1;
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
